// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
// Stall side of operand bypassing for the 5-stage core: one-bubble load-use
// interlock, full-pipeline freeze while a data-memory access is pending, and a
// sticky watchdog fault when that wait exceeds MEM_TIMEOUT cycles.
module hazard_stall_unit #(
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rest,
  input  logic [3:0]  IFID_Register_Rd,
  input  logic [3:0]  IFID_Register_Rt,
  input  logic        IFID_UsesRd,
  input  logic        IFID_UsesRt,
  input  logic        IFIDMemRead,
  input  logic        IFIDMemWrite,
  input  logic [3:0]  IDEX_Register_Rd,
  input  logic        IDEXMemRead,
  input  logic        EXMEMMemAccess,
  input  logic        mem_ready,
  input  logic        perf_clr,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IDEXFlush,
  output logic        PipeWrite,
  output logic        mem_fault,
  output logic [15:0] stall_cycles
);

  // Loads and stores implicitly read this register as their base address.
  localparam logic [3:0] BASE_REG_C  = 4'd10;
  localparam logic [7:0] TIMEOUT_C   = 8'(MEM_TIMEOUT);
  localparam logic [15:0] STALL_MAX_C = 16'hFFFF;

  // Code 2'b11 is unused and decodes to the fault behaviour.
  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_MEMWAIT = 2'b01,
    ST_FAULT   = 2'b10
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [7:0]  wait_cnt_r;
  logic [7:0]  wait_cnt_s;
  logic        mem_fault_r;
  logic [15:0] stall_cycles_r;

  logic        lu_s;
  logic        mw_s;
  logic        in_fault_s;
  logic        pc_write_s;
  logic        ifid_write_s;
  logic        pipe_write_s;
  logic        idex_flush_s;

  // Load-use and memory-wait hazard detection; r0 never creates a hazard.
  always_comb begin
    lu_s = 1'b0;
    mw_s = EXMEMMemAccess & ~mem_ready;
    if (IDEXMemRead && (IDEX_Register_Rd != 4'd0)) begin
      lu_s = (IFID_UsesRd && (IFID_Register_Rd == IDEX_Register_Rd)) ||
             (IFID_UsesRt && (IFID_Register_Rt == IDEX_Register_Rd)) ||
             ((IFIDMemRead || IFIDMemWrite) && (IDEX_Register_Rd == BASE_REG_C));
    end else begin
      lu_s = 1'b0;
    end
  end

  // Next-state, wait counter and pipeline enables; default is fully frozen.
  always_comb begin
    state_s      = state_r;
    wait_cnt_s   = wait_cnt_r;
    in_fault_s   = 1'b0;
    pc_write_s   = 1'b0;
    ifid_write_s = 1'b0;
    pipe_write_s = 1'b0;
    idex_flush_s = 1'b0;
    if (!rest) begin
      // Held in reset: front end stopped and ID/EX forced to a bubble.
      state_s      = ST_RUN;
      wait_cnt_s   = 8'd0;
      idex_flush_s = 1'b1;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (mw_s) begin
            state_s    = ST_MEMWAIT;
            wait_cnt_s = 8'd1;
          end else if (lu_s) begin
            pipe_write_s = 1'b1;
            idex_flush_s = 1'b1;
          end else begin
            pc_write_s   = 1'b1;
            ifid_write_s = 1'b1;
            pipe_write_s = 1'b1;
          end
        end
        ST_MEMWAIT: begin
          if (mem_ready) begin
            // Release cycle advances normally, still honouring a load-use.
            state_s    = ST_RUN;
            wait_cnt_s = 8'd0;
            if (lu_s) begin
              pipe_write_s = 1'b1;
              idex_flush_s = 1'b1;
            end else begin
              pc_write_s   = 1'b1;
              ifid_write_s = 1'b1;
              pipe_write_s = 1'b1;
            end
          end else if (wait_cnt_r == TIMEOUT_C) begin
            state_s = ST_FAULT;
          end else begin
            wait_cnt_s = 8'(wait_cnt_r + 8'd1);
          end
        end
        ST_FAULT: begin
          in_fault_s = 1'b1;
          state_s    = ST_FAULT;
        end
        default: begin
          in_fault_s = 1'b1;
          state_s    = ST_FAULT;
        end
      endcase
    end
  end

  // State, wait counter and sticky fault flag.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state_r     <= ST_RUN;
      wait_cnt_r  <= 8'd0;
      mem_fault_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      wait_cnt_r  <= wait_cnt_s;
      mem_fault_r <= mem_fault_r | (state_s == ST_FAULT);
    end
  end

  // Saturating stall counter; clear wins over increment, fault cycles excluded.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      stall_cycles_r <= 16'd0;
    end else if (perf_clr) begin
      stall_cycles_r <= 16'd0;
    end else if (!pc_write_s && !in_fault_s && (stall_cycles_r != STALL_MAX_C)) begin
      stall_cycles_r <= stall_cycles_r + 16'd1;
    end else begin
      stall_cycles_r <= stall_cycles_r;
    end
  end

  assign PCWrite      = pc_write_s;
  assign IFIDWrite    = ifid_write_s;
  assign PipeWrite    = pipe_write_s;
  assign IDEXFlush    = idex_flush_s;
  assign mem_fault    = mem_fault_r;
  assign stall_cycles = stall_cycles_r;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit (MEM_TIMEOUT = 4).
// Inputs change on the falling edge; the expected outputs for that cycle are
// queued, then popped and compared 2 time units later, before the next rising edge.
module tb_hazard_stall_unit;

  logic        clk = 1'b0;
  logic        rest;
  logic [3:0]  IFID_Register_Rd, IFID_Register_Rt, IDEX_Register_Rd;
  logic        IFID_UsesRd, IFID_UsesRt, IFIDMemRead, IFIDMemWrite;
  logic        IDEXMemRead, EXMEMMemAccess, mem_ready, perf_clr;
  logic        PCWrite, IFIDWrite, IDEXFlush, PipeWrite, mem_fault;
  logic [15:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        pcw, ifw, pw, fl, flt;
    logic [15:0] sc;
  } exp_t;

  exp_t sb_q[$];
  logic [15:0] model_sc;

  hazard_stall_unit #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rest(rest),
    .IFID_Register_Rd(IFID_Register_Rd), .IFID_Register_Rt(IFID_Register_Rt),
    .IFID_UsesRd(IFID_UsesRd), .IFID_UsesRt(IFID_UsesRt),
    .IFIDMemRead(IFIDMemRead), .IFIDMemWrite(IFIDMemWrite),
    .IDEX_Register_Rd(IDEX_Register_Rd), .IDEXMemRead(IDEXMemRead),
    .EXMEMMemAccess(EXMEMMemAccess), .mem_ready(mem_ready), .perf_clr(perf_clr),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXFlush(IDEXFlush),
    .PipeWrite(PipeWrite), .mem_fault(mem_fault), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // Queue this cycle's expectation; stall count is the value registered so far,
  // and the reference counter then advances as the hardware should at the edge.
  task automatic sb_push(input string name, input logic pcw, input logic ifw,
                         input logic pw, input logic fl, input logic flt);
    exp_t e;
    if (!rest) model_sc = 16'd0;
    e.name = name; e.pcw = pcw; e.ifw = ifw; e.pw = pw; e.fl = fl; e.flt = flt;
    e.sc = model_sc;
    sb_q.push_back(e);
    if (!rest || perf_clr) model_sc = 16'd0;
    else if (!pcw && !flt && model_sc != 16'hFFFF) model_sc = model_sc + 16'd1;
  endtask

  task automatic idle_inputs();
    IFID_Register_Rd = 4'd1; IFID_Register_Rt = 4'd2; IDEX_Register_Rd = 4'd0;
    IFID_UsesRd = 1'b0; IFID_UsesRt = 1'b0; IFIDMemRead = 1'b0; IFIDMemWrite = 1'b0;
    IDEXMemRead = 1'b0; EXMEMMemAccess = 1'b0; mem_ready = 1'b1; perf_clr = 1'b0;
  endtask

  task automatic set_lu(input logic [3:0] ex_rd, input logic [3:0] rd, input logic [3:0] rt,
                        input logic use_rd, input logic use_rt, input logic ld, input logic st);
    IDEXMemRead = 1'b1; IDEX_Register_Rd = ex_rd;
    IFID_Register_Rd = rd; IFID_Register_Rt = rt;
    IFID_UsesRd = use_rd; IFID_UsesRt = use_rt; IFIDMemRead = ld; IFIDMemWrite = st;
  endtask

  task automatic test_reset();
    exp_t e;
    @(negedge clk);
    idle_inputs(); rest = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sb_push("reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      #2;
      e = sb_q.pop_front();
      checks++;
      if ({PCWrite, IFIDWrite, PipeWrite, IDEXFlush, mem_fault} !== {e.pcw, e.ifw, e.pw, e.fl, e.flt}) begin
        errors++; $display("FAIL %s: pcw/ifw/pw/fl/flt got %b%b%b%b%b want %b%b%b%b%b", e.name,
          PCWrite, IFIDWrite, PipeWrite, IDEXFlush, mem_fault, e.pcw, e.ifw, e.pw, e.fl, e.flt);
      end
      checks++;
      if (stall_cycles !== e.sc) begin
        errors++; $display("FAIL %s stall_cycles: got %0d want %0d", e.name, stall_cycles, e.sc);
      end
      @(negedge clk);
    end
    rest = 1'b1;
  endtask

  task automatic test_load_use();
    exp_t e;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      idle_inputs();
      case (i)
        0: begin set_lu(4'd3, 4'd1, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0); sb_push("lu_rt3", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); end
        1: sb_push("lu_after_bubble", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        2: begin set_lu(4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0); sb_push("lu_r0", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); end
        3: begin set_lu(4'd10, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1); sb_push("lu_store_base", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); end
        4: begin set_lu(4'd10, 4'd1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0); sb_push("lu_load_base", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); end
        5: begin set_lu(4'd9, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1); sb_push("lu_store_r9", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); end
        6: begin set_lu(4'd7, 4'd7, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0); sb_push("lu_rd7", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); end
        7: begin set_lu(4'd7, 4'd7, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0); sb_push("lu_unused_match", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); end
        8: begin set_lu(4'd5, 4'd3, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0); sb_push("lu_nomatch", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); end
        default: begin set_lu(4'd5, 4'd5, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0); IDEXMemRead = 1'b0;
                       sb_push("lu_not_load", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); end
      endcase
      #2;
      e = sb_q.pop_front();
      checks++;
      if ({PCWrite, IFIDWrite, PipeWrite, IDEXFlush, mem_fault} !== {e.pcw, e.ifw, e.pw, e.fl, e.flt}) begin
        errors++; $display("FAIL %s: pcw/ifw/pw/fl/flt got %b%b%b%b%b want %b%b%b%b%b", e.name,
          PCWrite, IFIDWrite, PipeWrite, IDEXFlush, mem_fault, e.pcw, e.ifw, e.pw, e.fl, e.flt);
      end
      checks++;
      if (stall_cycles !== e.sc) begin
        errors++; $display("FAIL %s stall_cycles: got %0d want %0d", e.name, stall_cycles, e.sc);
      end
    end
  endtask

  task automatic test_mem_wait();
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      idle_inputs();
      if (i < 5) set_lu(4'd4, 4'd4, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
      if (i < 3 || i == 6) begin EXMEMMemAccess = 1'b1; mem_ready = 1'b0; end
      else if (i < 5) EXMEMMemAccess = 1'b1;
      else EXMEMMemAccess = 1'b0;
      if (i < 3)       sb_push("mw_frozen", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      else if (i == 3) sb_push("mw_release_lu", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      else if (i == 4) sb_push("mw_run_lu", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      else if (i == 6) sb_push("mw_again", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      else             sb_push("mw_after", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      #2;
      e = sb_q.pop_front();
      checks++;
      if ({PCWrite, IFIDWrite, PipeWrite, IDEXFlush, mem_fault} !== {e.pcw, e.ifw, e.pw, e.fl, e.flt}) begin
        errors++; $display("FAIL %s[%0d]: pcw/ifw/pw/fl/flt got %b%b%b%b%b want %b%b%b%b%b", e.name, i,
          PCWrite, IFIDWrite, PipeWrite, IDEXFlush, mem_fault, e.pcw, e.ifw, e.pw, e.fl, e.flt);
      end
      checks++;
      if (stall_cycles !== e.sc) begin
        errors++; $display("FAIL %s[%0d] stall_cycles: got %0d want %0d", e.name, i, stall_cycles, e.sc);
      end
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      idle_inputs();
      if (i < 6) begin EXMEMMemAccess = 1'b1; mem_ready = 1'b0; end
      if (i == 8 || i == 9) rest = 1'b0; else rest = 1'b1;
      if (i < 5)       sb_push("to_wait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      else if (i < 8)  sb_push("to_fault", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      else if (i < 10) sb_push("to_reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      else             sb_push("to_run", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      #2;
      e = sb_q.pop_front();
      checks++;
      if ({PCWrite, IFIDWrite, PipeWrite, IDEXFlush, mem_fault} !== {e.pcw, e.ifw, e.pw, e.fl, e.flt}) begin
        errors++; $display("FAIL %s[%0d]: pcw/ifw/pw/fl/flt got %b%b%b%b%b want %b%b%b%b%b", e.name, i,
          PCWrite, IFIDWrite, PipeWrite, IDEXFlush, mem_fault, e.pcw, e.ifw, e.pw, e.fl, e.flt);
      end
      checks++;
      if (stall_cycles !== e.sc) begin
        errors++; $display("FAIL %s[%0d] stall_cycles: got %0d want %0d", e.name, i, stall_cycles, e.sc);
      end
    end
    rest = 1'b1;
  endtask

  task automatic test_saturation();
    exp_t e;
    @(negedge clk);
    idle_inputs();
    set_lu(4'd3, 4'd3, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    // 65540 consecutive load-use stalls from zero: well past 0xFFFF.
    perf_clr = 1'b1;
    @(negedge clk);
    perf_clr = 1'b0;
    repeat (65540) @(negedge clk);
    model_sc = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      perf_clr = (i == 1);
      sb_push("sat", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      #2;
      e = sb_q.pop_front();
      checks++;
      if ({PCWrite, IFIDWrite, PipeWrite, IDEXFlush, mem_fault} !== {e.pcw, e.ifw, e.pw, e.fl, e.flt}) begin
        errors++; $display("FAIL %s[%0d]: pcw/ifw/pw/fl/flt got %b%b%b%b%b want %b%b%b%b%b", e.name, i,
          PCWrite, IFIDWrite, PipeWrite, IDEXFlush, mem_fault, e.pcw, e.ifw, e.pw, e.fl, e.flt);
      end
      checks++;
      if (stall_cycles !== e.sc) begin
        errors++; $display("FAIL %s[%0d] stall_cycles: got %0d want %0d", e.name, i, stall_cycles, e.sc);
      end
    end
    perf_clr = 1'b0;
  endtask

  initial begin
    model_sc = 16'd0;
    idle_inputs();
    rest = 1'b0;
    test_reset();
    test_load_use();
    test_mem_wait();
    test_timeout();
    test_saturation();
    checks++;
    if (sb_q.size() !== 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d entries want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Pipeline hazard controller for the 16-register, 5-stage core. It is the stall side of operand bypassing: wherever the bypass network cannot supply an operand in time, this block holds the front of the pipeline. It inserts a single bubble on a load-use dependency. It freezes the whole pipeline while a data-memory access in EX/MEM is still waiting on `mem_ready`. A watchdog raises a sticky fault if that wait runs too long.

## Interface
- `MEM_TIMEOUT`, 64: maximum number of consecutive wait cycles before a memory fault is raised; legal range 2..255.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rest` in 1: asynchronous, active-low reset.
- `IFID_Register_Rd` in 4: ID-stage source A register; the Rd field doubles as a source in this ISA.
- `IFID_Register_Rt` in 4: ID-stage source B register.
- `IFID_UsesRd` in 1: the ID instruction reads Rd as an operand.
- `IFID_UsesRt` in 1: the ID instruction reads Rt.
- `IFIDMemRead` in 1: the ID instruction is a load. Loads implicitly read r10 as the base register.
- `IFIDMemWrite` in 1: the ID instruction is a store. Stores implicitly read r10 as the base register.
- `IDEX_Register_Rd` in 4: EX-stage destination register.
- `IDEXMemRead` in 1: the EX instruction is a load.
- `EXMEMMemAccess` in 1: the MEM-stage instruction accesses data memory.
- `mem_ready` in 1: the data memory completes the current access this cycle.
- `perf_clr` in 1: synchronous clear of `stall_cycles`.
- `PCWrite` out 1: enable for the PC register.
- `IFIDWrite` out 1: enable for the IF/ID register.
- `IDEXFlush` out 1: load a bubble into ID/EX (all control bits 0).
- `PipeWrite` out 1: enable for ID/EX, EX/MEM and MEM/WB. When 0 those three registers hold.
- `mem_fault` out 1: sticky memory-timeout error.
- `stall_cycles` out 16: saturating count of stall cycles.

## Operation
- Register r0 is hardwired to zero. A destination of 0 never creates a hazard.
- The load-use hazard `lu` is 1 when all of the following hold:
  - `IDEXMemRead` is 1 and `IDEX_Register_Rd` is not 0.
  - At least one of these matches: (`IFID_UsesRd` and `IFID_Register_Rd` = `IDEX_Register_Rd`), (`IFID_UsesRt` and `IFID_Register_Rt` = `IDEX_Register_Rd`), or ((`IFIDMemRead` or `IFIDMemWrite`) and `IDEX_Register_Rd` = 10).
- The memory wait condition `mw` is `EXMEMMemAccess` and not `mem_ready`.
- The state machine has three states: RUN, MEMWAIT and FAULT. It is encoded in 2 bits, and the unused code decodes to FAULT.
- **RUN:**
  - If `mw`: `PCWrite`=0, `IFIDWrite`=0, `PipeWrite`=0, `IDEXFlush`=0. Next state MEMWAIT and `wait_cnt` ← 1. `mw` has priority over `lu`.
  - Else if `lu`: `PCWrite`=0, `IFIDWrite`=0, `PipeWrite`=1, `IDEXFlush`=1. Stay in RUN.
  - Else: `PCWrite`=1, `IFIDWrite`=1, `PipeWrite`=1, `IDEXFlush`=0.
- **MEMWAIT:**
  - If `mem_ready`=1: the outputs follow the RUN rules above with `mw`=0, including a pending `lu`. Next state RUN and `wait_cnt` ← 0.
  - Else: everything is frozen (same outputs as `mw` in RUN) and `wait_cnt` increments. When `wait_cnt` = `MEM_TIMEOUT` and `mem_ready` is still 0, next state FAULT.
- **FAULT:**
  - Everything is frozen.
  - `mem_fault`=1 from the first FAULT cycle onward.
  - Only `rest` leaves this state.
- `wait_cnt` is an 8-bit internal counter and never wraps in normal operation.
- `stall_cycles` increments on every cycle where `PCWrite`=0 and the state is not FAULT. It saturates at 0xFFFF. `perf_clr` has priority over the increment and yields 0 on the next edge.

## Timing
- Enables and flush are combinational from the inputs and the current state, so a hazard takes effect in the same cycle it is presented.
- State, `wait_cnt`, `mem_fault` and `stall_cycles` are registered.
- Load-use costs exactly one bubble cycle. In the following cycle the load is in MEM, `lu` falls because ID/EX now holds a bubble, and the operand comes from bypassing.
- A memory wait of N cycles with `mem_ready` low freezes the pipeline for exactly N cycles. The release cycle (`mem_ready`=1) advances normally.
- The fault is entered on the edge after the wait cycle where `wait_cnt` = `MEM_TIMEOUT`. `mem_fault` is therefore 1 after `MEM_TIMEOUT`+1 unready cycles.
- Reset values while `rest`=0:
  - state RUN, `wait_cnt`=0, `mem_fault`=0, `stall_cycles`=0.
  - `PCWrite`=0, `IFIDWrite`=0, `PipeWrite`=0, `IDEXFlush`=1.
- A reset asserted mid-wait or in FAULT clears everything immediately (asynchronously). The first edge after release behaves as RUN.

## Test plan
- Load into r3 in EX, ID uses Rt=3 -> one cycle with `PCWrite`=0, `IFIDWrite`=0, `IDEXFlush`=1; next cycle all enables 1; `stall_cycles`=1.
- Load into r0, ID uses Rd=0 -> no stall, enables 1, `IDEXFlush`=0.
- Load into r10 in EX, ID is a store with `IFID_UsesRd`=0 and `IFID_UsesRt`=0 -> one-cycle bubble from the implicit base read.
- `EXMEMMemAccess`=1 with `mem_ready` low for 3 cycles plus a simultaneous `lu` -> 3 fully frozen cycles with `IDEXFlush`=0, then the release cycle applies the bubble; `stall_cycles`=4.
- `MEM_TIMEOUT`=4 with `mem_ready` held low -> `mem_fault`=1 after 5 wait cycles and the pipeline stays frozen. Pulsing `rest` low clears the fault and `stall_cycles`, and the state returns to RUN.
- `stall_cycles` preset near 0xFFFF by stalling -> it holds at 0xFFFF. `perf_clr` asserted during a stall -> 0 on the next edge.
